// File: rtl/bg_rom_arbiter.sv
// bg_rom_arbiter
//   Two-port pipelined arbiter in front of the single combinational-read background ROM.
//   Port 0 (VGA pixel fetch) has fixed priority over port 1 (auxiliary reader).
//   Stage A registers the winning address onto rom_addr and pulses that port's gnt.
//   Stage B captures rom_data one edge later and returns it with an rvalid pulse.
//   Addresses >= DEPTH are still granted. They leave rom_addr untouched and return
//   zero data with the port's oob strobe.
//
// Optional feature: define BG_ARB_STARVE_GUARD_EN to force-grant port 1 after MAX_WAIT
//   consecutive denied cycles. Without it, priority is strictly fixed and no wait
//   counter exists.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req0/addr0              port 0 request and address (held while req0 is high)
//   gnt0                    one-cycle pulse: port 0 address accepted
//   rvalid0/rdata0/oob0     port 0 return strobe, data (held between pulses), out-of-range
//   req1/addr1/gnt1/rvalid1/rdata1/oob1  same for port 1
//   rom_addr                registered ROM address
//   rom_data                combinational ROM output for rom_addr
module bg_rom_arbiter #(
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned DEPTH    = 307200,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  output logic              oob0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              oob1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam logic [ADDR_W-1:0] DepthLim = ADDR_W'(DEPTH);

  // Arbitration
  logic win0, win1;

`ifdef BG_ARB_STARVE_GUARD_EN
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  logic [WaitW-1:0] wait_q, wait_d;
  logic             force1;

  assign force1 = req1 && (wait_q == WaitW'(MAX_WAIT));

  always_comb begin
    win1 = req1 && (!req0 || force1);
    win0 = req0 && !win1;
  end

  // Counts consecutive denied cycles of port 1; any gap in req1 restarts the count.
  always_comb begin
    wait_d = wait_q;
    if (!req1 || win1) begin
      wait_d = '0;
    end else if (wait_q != WaitW'(MAX_WAIT)) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  logic unused_max_wait;
  assign unused_max_wait = ^MAX_WAIT;

  always_comb begin
    win0 = req0;
    win1 = req1 && !req0;
  end
`endif

  // Stage A: issue
  logic              any_win;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_oob;

  logic              a_valid_q, a_valid_d;
  logic              a_port_q, a_port_d;  // 0 = port 0, 1 = port 1
  logic              a_oob_q, a_oob_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;

  always_comb begin
    any_win    = win0 || win1;
    sel_addr   = win1 ? addr1 : addr0;
    sel_oob    = sel_addr >= DepthLim;
    a_valid_d  = any_win;
    a_port_d   = win1;
    a_oob_d    = any_win && sel_oob;
    gnt0_d     = win0;
    gnt1_d     = win1;
    rom_addr_d = rom_addr_q;
    // Out-of-range reads never reach the ROM bus.
    if (any_win && !sel_oob) begin
      rom_addr_d = sel_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q  <= 1'b0;
      a_port_q   <= 1'b0;
      a_oob_q    <= 1'b0;
      rom_addr_q <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
    end else begin
      a_valid_q  <= a_valid_d;
      a_port_q   <= a_port_d;
      a_oob_q    <= a_oob_d;
      rom_addr_q <= rom_addr_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
    end
  end

  // Stage B: return
  logic [DATA_W-1:0] ret_data;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic              oob0_q, oob0_d;
  logic              oob1_q, oob1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  always_comb begin
    ret_data  = a_oob_q ? '0 : rom_data;
    rvalid0_d = a_valid_q && !a_port_q;
    rvalid1_d = a_valid_q && a_port_q;
    oob0_d    = rvalid0_d && a_oob_q;
    oob1_d    = rvalid1_d && a_oob_q;
    rdata0_d  = rvalid0_d ? ret_data : rdata0_q;
    rdata1_d  = rvalid1_d ? ret_data : rdata1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      oob0_q    <= 1'b0;
      oob1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      oob0_q    <= oob0_d;
      oob1_q    <= oob1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign oob0     = oob0_q;
  assign oob1     = oob1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_bg_rom_arbiter.sv
// Scoreboard bench for bg_rom_arbiter: the driver pushes expected grants and read returns,
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_bg_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [18:0] addr0, addr1;
  logic        gnt0, gnt1, rvalid0, rvalid1, oob0, oob1;
  logic [11:0] rdata0, rdata1;
  logic [18:0] rom_addr;
  logic [11:0] rom_data;

  typedef struct {
    bit          port;
    bit          oob;
    logic [11:0] data;
    int          k;
  } rd_t;

  rd_t         exp_rd[$];
  logic [1:0]  exp_gnt = 2'b00;
  logic [11:0] hold0 = '0, hold1 = '0;
  int          neg_cnt = 0;
  int          checks = 0;
  int          failures = 0;
  int          wait_m = 0;

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_f(input logic [18:0] a);
    return a[11:0] ^ {5'b0, a[18:12]} ^ 12'ha5c;
  endfunction

  assign rom_data = rom_f(rom_addr);

  bg_rom_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .addr0    (addr0),
    .gnt0     (gnt0),
    .rvalid0  (rvalid0),
    .rdata0   (rdata0),
    .oob0     (oob0),
    .req1     (req1),
    .addr1    (addr1),
    .gnt1     (gnt1),
    .rvalid1  (rvalid1),
    .rdata1   (rdata1),
    .oob1     (oob1),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of requests and record what the arbiter must do with them.
  task automatic drive(input logic r0, input logic [18:0] a0,
                       input logic r1, input logic [18:0] a1);
    logic        w0, w1, frc;
    logic [18:0] wa;
    rd_t         e;
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    frc = 1'b0;
`ifdef BG_ARB_STARVE_GUARD_EN
    frc = r1 && (wait_m == 8);
`endif
    w1 = r1 && (!r0 || frc);
    w0 = r0 && !w1;
    @(posedge clk);
    exp_gnt = {w0, w1};
    if (w0 || w1) begin
      wa     = w1 ? a1 : a0;
      e.port = w1;
      e.oob  = (wa >= 19'd307200);
      e.data = e.oob ? 12'h000 : rom_f(wa);
      e.k    = neg_cnt;
      exp_rd.push_back(e);
    end
    if (!r1 || w1) wait_m = 0;
    else if (wait_m < 8) wait_m++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 19'($urandom), 1'b0, 19'($urandom));
  endtask

  always @(negedge clk) begin
    rd_t e;
    if (!rst_n) begin
      check("reset_outputs",
            {rom_addr, gnt0, gnt1, rvalid0, rvalid1, oob0, oob1, rdata0, rdata1}, 64'd0);
      hold0   = '0;
      hold1   = '0;
      exp_gnt = 2'b00;
    end else begin
      if (rvalid0 && rvalid1) begin
        check("single_rvalid", {rvalid0, rvalid1}, 2'b01);
      end else if (rvalid0 || rvalid1) begin
        if (exp_rd.size() == 0) begin
          check("unexpected_rvalid", {rvalid0, rvalid1}, 2'b00);
        end else begin
          e = exp_rd.pop_front();
          check("rd_port", rvalid1, e.port);
          check("rd_data", rvalid1 ? rdata1 : rdata0, e.data);
          check("rd_oob", rvalid1 ? oob1 : oob0, e.oob);
          check("rd_latency", neg_cnt + 1, e.k + 2);
          if (e.port) hold1 = e.data;
          else hold0 = e.data;
        end
      end
      check("cycle_gnt_oob_rdata",
            {gnt0, gnt1, oob0 & ~rvalid0, oob1 & ~rvalid1, rdata0, rdata1},
            {exp_gnt, 2'b00, hold0, hold1});
      exp_gnt = 2'b00;
    end
    neg_cnt++;
  end

  initial begin
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset with random traffic on the inputs.
    repeat (5) begin
      req0 = 1'($urandom); addr0 = 19'($urandom);
      req1 = 1'($urandom); addr1 = 19'($urandom);
      @(posedge clk);
      #1;
    end
    check("rom_addr_in_reset", rom_addr, 19'd0);
    rst_n  = 1'b1;
    wait_m = 0;

    // First edge after release grants port 0.
    drive(1'b1, 19'd5, 1'b0, 19'd0);
    idle(2);

    // Back-to-back port 0.
    for (int i = 0; i < 4; i++) drive(1'b1, 19'(i), 1'b0, 19'd0);
    idle(2);

    // Contention: port 1 waits (or is force-granted when the guard is built in).
    repeat (12) drive(1'b1, 19'd10, 1'b1, 19'd20);
    drive(1'b0, 19'd0, 1'b1, 19'd20);
    idle(2);

    // Range boundary and rom_addr hold on out-of-range.
    drive(1'b0, 19'd0, 1'b1, 19'd77);
    check("rom_addr_load", rom_addr, 19'd77);
    drive(1'b0, 19'd0, 1'b1, 19'd307200);
    check("rom_addr_hold_oob1", rom_addr, 19'd77);
    drive(1'b0, 19'd0, 1'b1, 19'd307199);
    check("rom_addr_last_word", rom_addr, 19'd307199);
    drive(1'b1, 19'd524287, 1'b0, 19'd0);
    check("rom_addr_hold_oob0", rom_addr, 19'd307199);
    drive(1'b1, 19'd300, 1'b1, 19'd301);
    drive(1'b0, 19'd0, 1'b1, 19'd302);
    drive(1'b1, 19'd303, 1'b0, 19'd0);
    idle(2);

    // Mid-flight reset: the in-flight port 0 read must never return.
    drive(1'b1, 19'd9, 1'b0, 19'd0);
    #1;
    rst_n = 1'b0;
    exp_rd.delete();
    exp_gnt = 2'b00;
    wait_m  = 0;
    req0    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);
    check("rdata0_after_midflight_reset", rdata0, 12'h000);

    drive(1'b0, 19'd0, 1'b1, 19'd1234);
    idle(3);
    check("scoreboard_drained", exp_rd.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
